// File: rtl/mips_intc_pkg.sv
// Shared definitions for the mips_intc interrupt controller: FSM states,
// register map addresses and STATUS register bit positions.
package mips_intc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } intc_state_e;

    localparam logic [1:0] INTC_MASK  = 2'd0;
    localparam logic [1:0] INTC_PEND  = 2'd1;
    localparam logic [1:0] INTC_STAT  = 2'd2;
    localparam logic [1:0] INTC_SWINT = 2'd3;

    localparam int STAT_IRQ_BIT = 0;
    localparam int STAT_SVC_BIT = 1;
    localparam int STAT_ID_LSB  = 8;

endpackage

// File: rtl/mips_intc_prienc.sv
// Lowest-index-first priority encoder: reports the id of the lowest set
// request bit and whether any bit is set.
module mips_intc_prienc #(
    parameter int N   = 8,
    parameter int IDW = 3
) (
    input  logic [N-1:0]   req,
    output logic [IDW-1:0] id,
    output logic           valid
);

    // Scan from the top so the lowest set index is the last one written.
    always_comb begin
        id    = '0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                id    = IDW'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mips_intc.sv
// Interrupt controller for the MIPS core: edge capture, masking, priority and
// the ack/service/done handshake. Define INTC_SYNC_EN to add a 2-flop input synchronizer.
module mips_intc
    import mips_intc_pkg::*;
#(
    parameter int NUM_IRQ = 8,
    parameter int ID_W    = 3
) (
    input  logic               ph1,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] interrupts,
    input  logic               int_ack,
    input  logic               int_done,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_addr,
    input  logic [31:0]        cfg_wdata,
    output logic [31:0]        cfg_rdata,
    output logic               irq,
    output logic [ID_W-1:0]    irq_id,
    output logic               in_service
);

    intc_state_e        state;
    logic [NUM_IRQ-1:0] line_in, prev, set_edge, pending, mask, eligible;
    logic [NUM_IRQ-1:0] sw_set, w1c, ack_clr, wdata_bits;
    logic [ID_W-1:0]    active_id, enc_id;
    logic               enc_valid, irq_q, svc_q;
    logic [31:0]        status;

`ifdef INTC_SYNC_EN
    logic [NUM_IRQ-1:0] sync1, sync2;

    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= interrupts;
            sync2 <= sync1;
        end
    end

    assign line_in = sync2;
`else
    assign line_in = interrupts;
`endif

    assign wdata_bits = cfg_wdata[NUM_IRQ-1:0];

    generate
        if (NUM_IRQ < 32) begin : g_wdata_spare
            logic unused_wdata;
            assign unused_wdata = &{1'b0, cfg_wdata[31:NUM_IRQ]};
        end
    endgenerate

    assign set_edge = line_in & ~prev;
    assign eligible = pending & mask;
    assign sw_set   = (cfg_we && cfg_addr == INTC_SWINT) ? wdata_bits : '0;
    assign w1c      = (cfg_we && cfg_addr == INTC_PEND)  ? wdata_bits : '0;
    assign ack_clr  = (state == REQ && int_ack && enc_valid) ? (NUM_IRQ'(1) << enc_id) : '0;

    mips_intc_prienc #(
        .N   (NUM_IRQ),
        .IDW (ID_W)
    ) u_prienc (
        .req   (eligible),
        .id    (enc_id),
        .valid (enc_valid)
    );

    // New edges and software sets are OR-ed in after clearing, so set wins.
    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            prev    <= '0;
            pending <= '0;
            mask    <= '0;
        end else begin
            prev    <= line_in;
            pending <= (pending & ~(w1c | ack_clr)) | set_edge | sw_set;
            if (cfg_we && cfg_addr == INTC_MASK)
                mask <= wdata_bits;
        end
    end

    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            irq_q     <= 1'b0;
            svc_q     <= 1'b0;
            active_id <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enc_valid) begin
                        state <= REQ;
                        irq_q <= 1'b1;
                    end
                end
                REQ: begin
                    if (int_ack) begin
                        state     <= SERVICE;
                        irq_q     <= 1'b0;
                        svc_q     <= 1'b1;
                        active_id <= enc_id;
                    end else if (!enc_valid) begin
                        state <= IDLE;
                        irq_q <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (int_done) begin
                        state     <= IDLE;
                        svc_q     <= 1'b0;
                        active_id <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    irq_q <= 1'b0;
                    svc_q <= 1'b0;
                end
            endcase
        end
    end

    assign irq        = irq_q;
    assign in_service = svc_q;
    assign irq_id     = (state == SERVICE) ? active_id : enc_id;

    always_comb begin
        status                             = '0;
        status[STAT_IRQ_BIT]               = irq_q;
        status[STAT_SVC_BIT]               = svc_q;
        status[STAT_ID_LSB +: ID_W]        = active_id;
    end

    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            INTC_MASK:  cfg_rdata = 32'(mask);
            INTC_PEND:  cfg_rdata = 32'(pending);
            INTC_STAT:  cfg_rdata = status;
            INTC_SWINT: cfg_rdata = '0;
            default:    cfg_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_mips_intc.sv
// Self-checking bench for mips_intc: directed scenarios followed by random
// traffic, all compared cycle by cycle against a behavioural model.
module tb_mips_intc;

    logic        ph1 = 1'b0;
    logic        reset;
    logic [7:0]  interrupts;
    logic        int_ack, int_done, cfg_we;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;
    logic        irq, in_service;
    logic [2:0]  irq_id;

    int checks = 0;
    int errors = 0;

    // Behavioural model state: plain bit vectors and two mode flags.
    logic [7:0] m_pend, m_mask, m_prev, m_s1, m_s2;
    bit         m_req, m_svc;
    int         m_act;

    mips_intc #(.NUM_IRQ(8), .ID_W(3)) dut (
        .ph1        (ph1),
        .reset      (reset),
        .interrupts (interrupts),
        .int_ack    (int_ack),
        .int_done   (int_done),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .cfg_rdata  (cfg_rdata),
        .irq        (irq),
        .irq_id     (irq_id),
        .in_service (in_service)
    );

    always #5 ph1 = ~ph1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %h, expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++)
            if (v[i]) return i;
        return 0;
    endfunction

    function automatic logic [31:0] expId();
        if (m_svc) return 32'(m_act);
        return 32'(lowest(m_pend & m_mask));
    endfunction

    function automatic logic [31:0] expRead(input logic [1:0] addr);
        case (addr)
            2'd0:    return {24'b0, m_mask};
            2'd1:    return {24'b0, m_pend};
            2'd2:    return {21'b0, 3'(m_act), 6'b0, m_svc, m_req};
            default: return 32'b0;
        endcase
    endfunction

    task automatic modelReset();
        m_pend = '0; m_mask = '0; m_prev = '0; m_s1 = '0; m_s2 = '0;
        m_req = 0; m_svc = 0; m_act = 0;
    endtask

    task automatic modelStep(input logic [7:0] intr, input logic ack, input logic done,
                             input logic we, input logic [1:0] addr, input logic [31:0] wdata);
        logic [7:0] line, elig, clr, set;
        int id;
        bit nreq, nsvc;
        int nact;
`ifdef INTC_SYNC_EN
        line = m_s2;
`else
        line = intr;
`endif
        elig = m_pend & m_mask;
        id   = lowest(elig);
        set  = line & ~m_prev;
        clr  = '0;
        if (we && addr == 2'd1) clr = wdata[7:0];
        if (we && addr == 2'd3) set = set | wdata[7:0];
        nreq = m_req; nsvc = m_svc; nact = m_act;
        if (m_svc) begin
            if (done) begin nsvc = 0; nact = 0; end
        end else if (m_req) begin
            if (ack) begin
                nreq = 0; nsvc = 1; nact = id;
                if (elig != 0) clr = clr | (8'd1 << id);
            end else if (elig == 0) begin
                nreq = 0;
            end
        end else if (elig != 0) begin
            nreq = 1;
        end
        m_pend = (m_pend & ~clr) | set;
        if (we && addr == 2'd0) m_mask = wdata[7:0];
        m_prev = line;
        m_s2 = m_s1;
        m_s1 = intr;
        m_req = nreq; m_svc = nsvc; m_act = nact;
    endtask

    // One ph1 cycle: drive inputs, check before and after the edge.
    task automatic applyStimulus(input logic [7:0] intr, input logic ack, input logic done,
                                 input logic we, input logic [1:0] addr, input logic [31:0] wdata);
        interrupts = intr; int_ack = ack; int_done = done;
        cfg_we = we; cfg_addr = addr; cfg_wdata = wdata;
        #1;
        checkOutput("pre_irq_id", 32'(irq_id), expId());
        checkOutput("pre_rdata", cfg_rdata, expRead(addr));
        @(posedge ph1);
        modelStep(intr, ack, done, we, addr, wdata);
        #1;
        checkOutput("irq", 32'(irq), 32'(m_req));
        checkOutput("in_service", 32'(in_service), 32'(m_svc));
        checkOutput("irq_id", 32'(irq_id), expId());
        checkOutput("rdata", cfg_rdata, expRead(addr));
    endtask

    initial begin
        logic [7:0]  r_intr;
        logic        r_ack, r_done, r_we;
        logic [1:0]  r_addr;
        logic [31:0] r_wdata;

        reset = 1'b0;
        interrupts = '0; int_ack = 0; int_done = 0;
        cfg_we = 0; cfg_addr = 2'd2; cfg_wdata = '0;
        modelReset();
        repeat (2) @(posedge ph1);
        #1;
        checkOutput("rst_irq", 32'(irq), 32'd0);
        checkOutput("rst_svc", 32'(in_service), 32'd0);
        checkOutput("rst_id", 32'(irq_id), 32'd0);
        checkOutput("rst_status", cfg_rdata, 32'd0);
        reset = 1'b1;

        // Single pulse, 2-edge latency, ack and done.
        applyStimulus(8'h00, 0, 0, 1, 2'd0, 32'h02);
        applyStimulus(8'h02, 0, 0, 0, 2'd2, 32'h0);
        checkOutput("tp1_no_irq_yet", 32'(irq), 32'd0);
        applyStimulus(8'h00, 0, 0, 0, 2'd2, 32'h0);
        checkOutput("tp1_irq", 32'(irq), 32'd1);
        checkOutput("tp1_id", 32'(irq_id), 32'd1);
        applyStimulus(8'h00, 1, 0, 0, 2'd1, 32'h0);
        checkOutput("tp1_ack_irq", 32'(irq), 32'd0);
        checkOutput("tp1_ack_svc", 32'(in_service), 32'd1);
        checkOutput("tp1_ack_pend", cfg_rdata, 32'd0);
        applyStimulus(8'h00, 0, 1, 0, 2'd2, 32'h0);
        checkOutput("tp1_done_status", cfg_rdata, 32'd0);

        // Simultaneous pulses on 0 and 1: id 0 first, then id 1.
        applyStimulus(8'h00, 0, 0, 1, 2'd0, 32'h03);
        applyStimulus(8'h03, 0, 0, 0, 2'd1, 32'h0);
        applyStimulus(8'h00, 0, 0, 0, 2'd1, 32'h0);
        checkOutput("tp2_first_id", 32'(irq_id), 32'd0);
        applyStimulus(8'h00, 1, 0, 0, 2'd2, 32'h0);
        applyStimulus(8'h00, 0, 1, 0, 2'd2, 32'h0);
        applyStimulus(8'h00, 0, 0, 0, 2'd2, 32'h0);
        checkOutput("tp2_second_irq", 32'(irq), 32'd1);
        checkOutput("tp2_second_id", 32'(irq_id), 32'd1);
        applyStimulus(8'h00, 1, 0, 0, 2'd2, 32'h0);
        applyStimulus(8'h00, 0, 1, 0, 2'd2, 32'h0);

        // Masked pulse stays pending; unmask raises irq two edges later.
        applyStimulus(8'h00, 0, 0, 1, 2'd0, 32'h00);
        applyStimulus(8'h02, 0, 0, 0, 2'd1, 32'h0);
        applyStimulus(8'h00, 0, 0, 0, 2'd1, 32'h0);
        checkOutput("tp3_pending", cfg_rdata, 32'h02);
        checkOutput("tp3_masked_irq", 32'(irq), 32'd0);
        applyStimulus(8'h00, 0, 0, 1, 2'd0, 32'h02);
        checkOutput("tp3_unmask_wait", 32'(irq), 32'd0);
        applyStimulus(8'h00, 0, 0, 0, 2'd1, 32'h0);
        checkOutput("tp3_unmask_irq", 32'(irq), 32'd1);

        // Withdrawal by masking while requesting.
        applyStimulus(8'h00, 0, 0, 1, 2'd0, 32'h00);
        applyStimulus(8'h00, 0, 0, 0, 2'd1, 32'h0);
        checkOutput("tp4_withdrawn", 32'(irq), 32'd0);
        checkOutput("tp4_pend_kept", cfg_rdata, 32'h02);

        // W1C collides with a new edge on the same bit: set wins.
        applyStimulus(8'h02, 0, 0, 1, 2'd1, 32'h02);
        checkOutput("tp5_set_wins", cfg_rdata, 32'h02);
        applyStimulus(8'h00, 0, 0, 1, 2'd1, 32'h02);
        checkOutput("tp5_cleared", cfg_rdata, 32'h00);

        // New edge during service waits for done; then async reset mid-service.
        applyStimulus(8'h00, 0, 0, 1, 2'd0, 32'h03);
        applyStimulus(8'h02, 0, 0, 0, 2'd2, 32'h0);
        applyStimulus(8'h00, 0, 0, 0, 2'd2, 32'h0);
        applyStimulus(8'h00, 1, 0, 0, 2'd2, 32'h0);
        applyStimulus(8'h01, 0, 0, 0, 2'd2, 32'h0);
        applyStimulus(8'h00, 0, 0, 0, 2'd2, 32'h0);
        checkOutput("tp6_no_nest", 32'(irq), 32'd0);
        checkOutput("tp6_status", cfg_rdata, 32'h0000_0102);
        applyStimulus(8'h00, 0, 1, 0, 2'd2, 32'h0);
        applyStimulus(8'h00, 0, 0, 0, 2'd2, 32'h0);
        checkOutput("tp6_after_done_irq", 32'(irq), 32'd1);
        checkOutput("tp6_after_done_id", 32'(irq_id), 32'd0);
        applyStimulus(8'h00, 1, 0, 0, 2'd2, 32'h0);
        reset = 1'b0;
        #1;
        checkOutput("async_rst_irq", 32'(irq), 32'd0);
        checkOutput("async_rst_svc", 32'(in_service), 32'd0);
        checkOutput("async_rst_id", 32'(irq_id), 32'd0);
        checkOutput("async_rst_status", cfg_rdata, 32'd0);
        modelReset();
        @(posedge ph1);
        #1;
        reset = 1'b1;

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            r_intr  = 8'($urandom & $urandom & $urandom);
            r_ack   = m_req ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 9) == 0);
            r_done  = m_svc ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
            r_we    = ($urandom_range(0, 5) == 0);
            r_addr  = 2'($urandom_range(0, 3));
            r_wdata = $urandom;
            applyStimulus(r_intr, r_ack, r_done, r_we, r_addr, r_wdata);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
